ps2_mouse_rx: RTL and testbench

PS/2 device-to-host receiver that feeds the mouse packet decoder. It deserializes 11-bit PS/2 frames (start, 8 data bits LSB first, odd parity, stop) from the raw ps2Clk/ps2Data lines. Each validated byte is delivered on mouseData with a one-cycle mouseReady strobe, which is exactly the byte interface the decoder consumes. Framing, parity and timeout errors are dropped and flagged on frameError.

---
 rtl/ps2_mouse_rx.sv | 131 +++++++++++++
 tb/tb_ps2_mouse_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_rx.sv
// PS/2 device-to-host byte receiver: synchronizes and debounces the raw lines,
// deserializes 11-bit frames and emits one strobe per frame (good byte or error).
module ps2_mouse_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] mouseData,
  output logic       mouseReady,
  output logic       frameError
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic              clk_s1_q, clk_s2_q;
  logic              dat_s1_q, dat_s2_q;
  logic              filt_q;
  logic              fall_q;
  logic [7:0]        fcnt_q;
  logic              filt_flip;

  state_t            state_q;
  logic [2:0]        bitcnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
  logic              par_q;
  logic [TCNT_W-1:0] tcnt_q;
  logic [7:0]        data_q;
  logic              ready_q;
  logic              err_q;

  assign filt_flip = (clk_s2_q != filt_q) && (fcnt_q == 8'(FILTER_LEN - 1));
  assign shift_d   = {dat_s2_q, shift_q[7:1]};

  // Stage 0: two-flop synchronizers; idle-high so reset cannot fake a fall
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2Clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2Data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Stage 1: glitch filter, any sample matching the current level restarts the run
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      fall_q <= filt_flip && filt_q;
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (filt_flip) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  // Stage 2: frame FSM; a fall event takes precedence over an expiring timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      tcnt_q   <= '0;
      data_q   <= 8'h00;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (fall_q) begin
        tcnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= STOP;
          end
          STOP: begin
            if (dat_s2_q && (^{shift_q, par_q})) begin
              data_q  <= shift_q;
              ready_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q == IDLE) begin
        tcnt_q <= '0;
      end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_q <= IDLE;
        tcnt_q  <= '0;
        err_q   <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign mouseData  = data_q;
  assign mouseReady = ready_q;
  assign frameError = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: drives PS/2 frames and compares strobes/data against
// a frame-level reference model (good byte iff odd parity holds and stop is 1).
module tb_ps2_mouse_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2Clk;
  logic       ps2Data;
  logic [7:0] mouseData;
  logic       mouseReady;
  logic       frameError;

  int checks   = 0;
  int failures = 0;

  ps2_mouse_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .mouseData (mouseData),
    .mouseReady(mouseReady),
    .frameError(frameError)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge
  int         cyc = 0;
  int         rdy_n = 0;
  int         err_n = 0;
  int         err_cyc = 0;
  int         viol = 0;
  int         last_fall_cyc = 0;
  logic       prev_rdy = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] rdy_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (mouseReady === 1'b1) begin
      rdy_q.push_back(mouseData);
      rdy_n = rdy_n + 1;
    end
    if (frameError === 1'b1) begin
      err_n   = err_n + 1;
      err_cyc = cyc;
    end
    if (mouseReady === 1'b1 && frameError === 1'b1) viol = viol + 1;
    if (mouseReady === 1'b1 && prev_rdy) viol = viol + 1;
    if (frameError === 1'b1 && prev_err) viol = viol + 1;
    prev_rdy = (mouseReady === 1'b1);
    prev_err = (frameError === 1'b1);
  end

  function automatic logic odd_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rdy_q.delete();
    rdy_n = 0;
    err_n = 0;
  endtask

  task automatic send_bit(input logic b);
    ps2Data = b;
    wait_cyc(25);
    ps2Clk = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(50);
    ps2Clk = 1'b1;
    wait_cyc(25);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stp);
  endtask

  task automatic expect_good(input string name, input logic [7:0] b);
    checks++;
    if (rdy_n !== 1 || err_n !== 0) begin
      failures++;
      $display("FAIL %s strobes: ready=%0d error=%0d, required ready=1 error=0", name, rdy_n, err_n);
    end
    checks++;
    if (mouseData !== b) begin
      failures++;
      $display("FAIL %s data: got %02h, required %02h", name, mouseData, b);
    end
  endtask

  task automatic expect_bad(input string name, input logic [7:0] keep);
    checks++;
    if (rdy_n !== 0 || err_n !== 1) begin
      failures++;
      $display("FAIL %s strobes: ready=%0d error=%0d, required ready=0 error=1", name, rdy_n, err_n);
    end
    checks++;
    if (mouseData !== keep) begin
      failures++;
      $display("FAIL %s held data: got %02h, required %02h", name, mouseData, keep);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2Clk = 1'b1; ps2Data = 1'b1;
    wait_cyc(4);
    checks++;
    if (mouseData !== 8'h00) begin
      failures++;
      $display("FAIL reset_data: got %02h, required 00", mouseData);
    end
    checks++;
    if (mouseReady !== 1'b0 || frameError !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes: ready=%b error=%b, required 0 0", mouseReady, frameError);
    end
    rst = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_single();
    clear_mon();
    send_frame(8'h08, 1'b0, 1'b1);
    wait_cyc(20);
    expect_good("single_08", 8'h08);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3] = '{8'h09, 8'h02, 8'hFD};
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp[i], odd_par(exp[i]), 1'b1);
    wait_cyc(20);
    checks++;
    if (rdy_n !== 3 || err_n !== 0) begin
      failures++;
      $display("FAIL b2b_count: ready=%0d error=%0d, required 3 0", rdy_n, err_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy_q.size() <= i || rdy_q[i] !== exp[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %02h, required %02h", i,
                 (rdy_q.size() > i) ? rdy_q[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_bad_frames();
    clear_mon();
    send_frame(8'h02, 1'b1, 1'b1);
    wait_cyc(20);
    expect_bad("bad_parity", 8'hFD);
    clear_mon();
    send_frame(8'h02, 1'b0, 1'b0);
    wait_cyc(20);
    expect_bad("bad_stop", 8'hFD);
  endtask

  task automatic test_glitch();
    clear_mon();
    ps2Clk = 1'b0;
    wait_cyc(2);
    ps2Clk = 1'b1;
    wait_cyc(30);
    checks++;
    if (rdy_n !== 0 || err_n !== 0) begin
      failures++;
      $display("FAIL glitch_strobe: ready=%0d error=%0d, required 0 0", rdy_n, err_n);
    end
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b1);
    wait_cyc(20);
    expect_good("after_glitch_00", 8'h00);
  endtask

  task automatic test_timeout();
    int d;
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    ps2Data = 1'b1;
    wait_cyc(1200);
    d = err_cyc - last_fall_cyc;
    checks++;
    if (rdy_n !== 0 || err_n !== 1) begin
      failures++;
      $display("FAIL timeout_strobes: ready=%0d error=%0d, required 0 1", rdy_n, err_n);
    end
    checks++;
    if (d < 995 || d > 1025) begin
      failures++;
      $display("FAIL timeout_delay: %0d cycles after last fall, required 995..1025", d);
    end
    clear_mon();
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    wait_cyc(20);
    expect_good("after_timeout_5A", 8'h5A);
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(1200);
    checks++;
    if (rdy_n !== 0 || err_n !== 0) begin
      failures++;
      $display("FAIL midreset_strobes: ready=%0d error=%0d, required 0 0", rdy_n, err_n);
    end
    checks++;
    if (mouseData !== 8'h00) begin
      failures++;
      $display("FAIL midreset_data: got %02h, required 00", mouseData);
    end
    clear_mon();
    send_frame(8'h03, odd_par(8'h03), 1'b1);
    wait_cyc(20);
    expect_good("after_reset_03", 8'h03);
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    int         exp_err;
    last_good = mouseData;
    exp_err = 0;
    clear_mon();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      int         kind;
      b    = 8'($urandom);
      kind = $urandom_range(0, 3);
      send_frame(b, odd_par(b) ^ (kind == 2), kind != 3);
      if (kind < 2) begin
        exp_q.push_back(b);
        last_good = b;
      end else begin
        exp_err++;
      end
    end
    wait_cyc(20);
    checks++;
    if (rdy_n !== exp_q.size() || err_n !== exp_err) begin
      failures++;
      $display("FAIL rand_count: ready=%0d error=%0d, required %0d %0d",
               rdy_n, err_n, exp_q.size(), exp_err);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rdy_q.size() <= i || rdy_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_byte%0d: got %02h, required %02h", i,
                 (rdy_q.size() > i) ? rdy_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++;
    if (mouseData !== last_good) begin
      failures++;
      $display("FAIL rand_held_data: got %02h, required %02h", mouseData, last_good);
    end
  endtask

  task automatic test_strobe_rules();
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL strobe_rules: %0d overlapping or multi-cycle strobes, required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bad_frames();
    test_glitch();
    test_timeout();
    test_reset_midframe();
    test_random();
    test_strobe_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
